ksa: RTL and testbench

//  RC4 key-scheduling stage, directly downstream of init. It runs after init has filled
//  s_mem with S[i]=i. It permutes S in place: for i=0..255: j=(j+S[i]+key[i mod KEY_LEN]) mod 256;

---
 rtl/rc4_pkg.sv | 17 +
 rtl/ksa.sv | 127 ++++++++++++
 tb/tb_ksa.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 types and constants for the init/ksa/prga pipeline.
package rc4_pkg;

   localparam int unsigned S_DEPTH         = 256;
   localparam int unsigned DEFAULT_KEY_LEN = 3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ_I  = 3'd1,
      CAPT_I  = 3'd2,
      READ_J  = 3'd3,
      CAPT_J  = 3'd4,
      WRITE_I = 3'd5,
      WRITE_J = 3'd6
   } ksa_state_t;

endpackage

// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes S in s_mem in place, six cycles per index i.
module ksa
   import rc4_pkg::*;
#(
   parameter int unsigned KEY_LEN = DEFAULT_KEY_LEN
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   output logic                   rdy,
   input  logic [8*KEY_LEN-1:0]   key,
   output logic [7:0]             addr,
   input  logic [7:0]             rddata,
   output logic [7:0]             wrdata,
   output logic                   wren
);

   localparam int unsigned KIDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

   ksa_state_t             state_q, state_d;
   logic [7:0]             i_q, i_d;
   logic [7:0]             j_q, j_d;
   logic [7:0]             si_q, si_d;
   logic [7:0]             sj_q, sj_d;
   logic [8*KEY_LEN-1:0]   key_q, key_d;
   logic [KIDX_W-1:0]      kidx_q, kidx_d;
   logic [7:0]             key_byte;

   // Byte 0 is the most significant key byte.
   always_comb begin
      key_byte = 8'h00;
      for (int k = 0; k < KEY_LEN; k++) begin
         if (kidx_q == KIDX_W'(k)) begin
            key_byte = key_q[8*(KEY_LEN-k)-1 -: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      si_d    = si_q;
      sj_d    = sj_q;
      key_d   = key_q;
      kidx_d  = kidx_q;
      unique case (state_q)
         IDLE: begin
            if (en) begin
               key_d   = key;
               i_d     = 8'h00;
               j_d     = 8'h00;
               kidx_d  = '0;
               state_d = READ_I;
            end
         end
         READ_I:  state_d = CAPT_I;
         CAPT_I: begin
            si_d    = rddata;
            j_d     = j_q + rddata + key_byte;
            state_d = READ_J;
         end
         READ_J:  state_d = CAPT_J;
         CAPT_J: begin
            sj_d    = rddata;
            state_d = WRITE_I;
         end
         WRITE_I: state_d = WRITE_J;
         WRITE_J: begin
            if (i_q == 8'hFF) begin
               state_d = IDLE;
            end else begin
               i_d     = i_q + 8'h01;
               kidx_d  = (kidx_q == KIDX_W'(KEY_LEN - 1)) ? '0 : kidx_q + KIDX_W'(1);
               state_d = READ_I;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= 8'h00;
         j_q     <= 8'h00;
         si_q    <= 8'h00;
         sj_q    <= 8'h00;
         key_q   <= '0;
         kidx_q  <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         key_q   <= key_d;
         kidx_q  <= kidx_d;
      end
   end

   always_comb begin
      rdy    = 1'b0;
      addr   = 8'h00;
      wrdata = 8'h00;
      wren   = 1'b0;
      unique case (state_q)
         IDLE:    rdy = 1'b1;
         READ_I:  addr = i_q;
         CAPT_I:  addr = i_q;
         READ_J:  addr = j_q;
         CAPT_J:  addr = j_q;
         WRITE_I: begin
            addr   = i_q;
            wrdata = sj_q;
            wren   = 1'b1;
         end
         WRITE_J: begin
            addr   = j_q;
            wrdata = si_q;
            wren   = 1'b1;
         end
         default: rdy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_ksa.sv
// Directed bench for ksa: s_mem model with 1-cycle read latency and a software KSA reference.
module tb_ksa;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        rdy;
   logic [23:0] key;
   logic [7:0]  addr;
   logic [7:0]  rddata;
   logic [7:0]  wrdata;
   logic        wren;

   logic [7:0]  mem [256];
   logic [7:0]  gold [256];
   logic [7:0]  wa [16];
   logic [7:0]  wd [16];
   int          nwr;
   int          nbusy;
   logic        preload;
   logic        clr;

   int          checks;
   int          failures;

   ksa #(.KEY_LEN(3)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .rdy    (rdy),
      .key    (key),
      .addr   (addr),
      .rddata (rddata),
      .wrdata (wrdata),
      .wren   (wren)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (preload) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
      end else if (wren) begin
         mem[addr] <= wrdata;
      end
      rddata <= mem[addr];
      if (clr) begin
         nwr   <= 0;
         nbusy <= 0;
      end else begin
         if (wren) begin
            if (nwr < 16) begin
               wa[nwr[3:0]] <= addr;
               wd[nwr[3:0]] <= wrdata;
            end
            nwr <= nwr + 1;
         end
         if (!rdy) nbusy <= nbusy + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compute_gold(input logic [23:0] k);
      logic [7:0] j;
      logic [7:0] t;
      logic [7:0] kb;
      for (int n = 0; n < 256; n++) gold[n] = 8'(n);
      j = 8'h00;
      for (int n = 0; n < 256; n++) begin
         kb = k[8*(3-(n%3))-1 -: 8];
         j  = j + gold[n] + kb;
         t  = gold[n];
         gold[n] = gold[j];
         gold[j] = t;
      end
   endtask

   task automatic prep();
      @(negedge clk);
      preload = 1'b1;
      clr     = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      clr     = 1'b0;
   endtask

   task automatic start(input logic [23:0] k);
      @(negedge clk);
      key = k;
      en  = 1'b1;
      @(negedge clk);
      en  = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!rdy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!rdy) check({tag, "_timeout"}, 32'(rdy), 32'd1);
   endtask

   task automatic check_mem(input string tag);
      int bad;
      bad = 0;
      for (int n = 0; n < 256; n++) begin
         if (mem[n] !== gold[n]) bad++;
      end
      check(tag, 32'(bad), 32'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      key      = 24'h0;
      preload  = 1'b0;
      clr      = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_rdy", 32'(rdy), 32'd1);
      check("reset_addr", 32'(addr), 32'd0);
      check("reset_wren", 32'(wren), 32'd0);
      rst_n = 1'b1;

      // Mid-run asynchronous reset, dropped between clock edges.
      prep();
      start(24'h00033C);
      check("busy_after_accept", 32'(rdy), 32'd0);
      repeat (20) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_rdy", 32'(rdy), 32'd1);
      check("async_rst_wren", 32'(wren), 32'd0);
      check("async_rst_addr", 32'(addr), 32'd0);
      check("async_rst_wrdata", 32'(wrdata), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // All-zero key: same-address pairs for i=0,1, then a real swap at i=2.
      prep();
      start(24'h000000);
      wait_idle("k0");
      check("k0_wa0", 32'(wa[0]), 32'h00);
      check("k0_wd0", 32'(wd[0]), 32'h00);
      check("k0_wa1", 32'(wa[1]), 32'h00);
      check("k0_wa2", 32'(wa[2]), 32'h01);
      check("k0_wd3", 32'(wd[3]), 32'h01);
      check("k0_wa4", 32'(wa[4]), 32'h02);
      check("k0_wd4", 32'(wd[4]), 32'h03);
      check("k0_wa5", 32'(wa[5]), 32'h03);
      check("k0_wd5", 32'(wd[5]), 32'h02);
      compute_gold(24'h000000);
      check_mem("k0_mem");

      // All-ones key exercises j wrap.
      prep();
      start(24'hFFFFFF);
      wait_idle("kf");
      check("kf_wa0", 32'(wa[0]), 32'h00);
      check("kf_wd0", 32'(wd[0]), 32'hFF);
      check("kf_wa1", 32'(wa[1]), 32'hFF);
      check("kf_wd1", 32'(wd[1]), 32'h00);
      check("kf_wa2", 32'(wa[2]), 32'h01);
      check("kf_wd2", 32'(wd[2]), 32'h00);
      check("kf_wa3", 32'(wa[3]), 32'hFF);
      check("kf_wd3", 32'(wd[3]), 32'h01);
      compute_gold(24'hFFFFFF);
      check_mem("kf_mem");

      // Full run with latency and write-count checks.
      prep();
      start(24'h00033C);
      wait_idle("full");
      check("full_busy_cycles", 32'(nbusy), 32'd1536);
      check("full_wren_pulses", 32'(nwr), 32'd512);
      compute_gold(24'h00033C);
      check_mem("full_mem");

      // en and key changes while busy must be ignored.
      prep();
      start(24'h00033C);
      repeat (10) @(negedge clk);
      key = 24'h123456;
      en  = 1'b1;
      @(negedge clk);
      en  = 1'b0;
      check("busy_ignore_rdy", 32'(rdy), 32'd0);
      wait_idle("busy");
      check("busy_cycles", 32'(nbusy), 32'd1536);
      check_mem("busy_mem");

      // Reset around i=100, then a clean restart.
      prep();
      start(24'h010203);
      repeat (603) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst100_rdy", 32'(rdy), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      prep();
      start(24'h00033C);
      wait_idle("rst100");
      check("rst100_busy", 32'(nbusy), 32'd1536);
      check("rst100_wa0", 32'(wa[0]), 32'h00);
      check_mem("rst100_mem");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
